resizer_master_port: RTL and testbench

- Output stage of the stream resizer, directly downstream of `buffer`.
- Consumes packed `master_entry` words of M_KEEP_WIDTH lanes and presents them as an AXI-Stream master (tdata/tkeep/tlast/tvalid/tready).
- A two-slot skid register gives full throughput with a registered ready toward `buffer`.
- Drops null entries, counts packets and flags non-contiguous keep patterns.

---
 rtl/resizer_master_port_if.sv | 39 +++
 rtl/resizer_master_port.sv | 145 ++++++++++++++
 tb/tb_resizer_master_port.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/resizer_master_port_if.sv
// Entry bus from the resizer buffer plus the AXI-Stream master bus.
// The master modport is the port block's view; slave is the buffer/sink side.
interface resizer_master_port_if #(
   parameter int T_DATA_WIDTH = 1,
   parameter int M_KEEP_WIDTH = 2
);
   localparam int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH;

   logic [BUF_OUT_ENTRY_SZ-1:0]            master_entry;
   logic                                   master_entry_valid;
   logic                                   master_entry_ready;
   logic                                   m_axis_tvalid;
   logic                                   m_axis_tready;
   logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0]   m_axis_tdata;
   logic [M_KEEP_WIDTH-1:0]                m_axis_tkeep;
   logic                                   m_axis_tlast;

   modport master (
      input  master_entry,
      input  master_entry_valid,
      output master_entry_ready,
      output m_axis_tvalid,
      input  m_axis_tready,
      output m_axis_tdata,
      output m_axis_tkeep,
      output m_axis_tlast
   );

   modport slave (
      output master_entry,
      output master_entry_valid,
      input  master_entry_ready,
      input  m_axis_tvalid,
      output m_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tkeep,
      input  m_axis_tlast
   );
endinterface

// File: rtl/resizer_master_port.sv
// Resizer output stage: decodes packed lane entries into an AXI-Stream master
// through a main/skid register pair, drops null entries, counts packets.
//
// state   | meaning
// EMPTY   | no beat held; tvalid=0, ready=1
// ONE     | main slot holds a beat; tvalid=1, ready=1
// TWO     | main and skid both hold beats; tvalid=1, ready=0
module resizer_master_port #(
   parameter int T_DATA_WIDTH  = 1,
   parameter int M_KEEP_WIDTH  = 2,
   parameter int PKT_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   resizer_master_port_if.master     bus,
   output logic [PKT_CNT_WIDTH-1:0]  pkt_count,
   output logic                      err_sparse
);
   localparam int L      = 2 + T_DATA_WIDTH;
   localparam int DATA_W = T_DATA_WIDTH * M_KEEP_WIDTH;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t                    state;
   logic                      ready_q;
   logic                      tvalid_q;
   logic [DATA_W-1:0]         main_data, skid_data;
   logic [M_KEEP_WIDTH-1:0]   main_keep, skid_keep;
   logic                      main_last, skid_last;
   logic [PKT_CNT_WIDTH-1:0]  pkt_q;
   logic                      err_q;

   logic [DATA_W-1:0]         dec_data;
   logic [M_KEEP_WIDTH-1:0]   dec_keep;
   logic [M_KEEP_WIDTH-1:0]   dec_last_v;
   logic                      dec_last;
   logic                      accept_nn;
   logic                      take;

   always_comb begin
      dec_data   = '0;
      dec_keep   = '0;
      dec_last_v = '0;
      for (int k = 0; k < M_KEEP_WIDTH; k++) begin
         dec_data[k*T_DATA_WIDTH +: T_DATA_WIDTH] = bus.master_entry[k*L +: T_DATA_WIDTH];
         dec_keep[k]   = bus.master_entry[k*L + T_DATA_WIDTH];
         dec_last_v[k] = bus.master_entry[k*L + T_DATA_WIDTH + 1];
      end
      dec_last = |dec_last_v;
   end

   // Null entries are still consumed (ready is honoured) but never stored.
   assign accept_nn = bus.master_entry_valid & ready_q & ((|dec_keep) | dec_last);
   assign take      = tvalid_q & bus.m_axis_tready;

   function automatic logic keep_contig(input logic [M_KEEP_WIDTH-1:0] k);
      logic [M_KEEP_WIDTH-1:0] kp1;
      kp1 = k + M_KEEP_WIDTH'(1);
      return ((k & kp1) == '0);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         ready_q   <= 1'b0;
         tvalid_q  <= 1'b0;
         main_data <= '0;
         main_keep <= '0;
         main_last <= 1'b0;
         skid_data <= '0;
         skid_keep <= '0;
         skid_last <= 1'b0;
         pkt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         if (take && main_last)
            pkt_q <= pkt_q + PKT_CNT_WIDTH'(1);
         if (take && !keep_contig(main_keep))
            err_q <= 1'b1;

         case (state)
            S_EMPTY: begin
               ready_q <= 1'b1;
               if (accept_nn) begin
                  main_data <= dec_data;
                  main_keep <= dec_keep;
                  main_last <= dec_last;
                  tvalid_q  <= 1'b1;
                  state     <= S_ONE;
               end
            end
            S_ONE: begin
               if (take) begin
                  ready_q <= 1'b1;
                  if (accept_nn) begin
                     main_data <= dec_data;
                     main_keep <= dec_keep;
                     main_last <= dec_last;
                  end else begin
                     tvalid_q <= 1'b0;
                     state    <= S_EMPTY;
                  end
               end else if (accept_nn) begin
                  // Sink stalled: park the new beat and close the input.
                  skid_data <= dec_data;
                  skid_keep <= dec_keep;
                  skid_last <= dec_last;
                  ready_q   <= 1'b0;
                  state     <= S_TWO;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_TWO: begin
               if (take) begin
                  main_data <= skid_data;
                  main_keep <= skid_keep;
                  main_last <= skid_last;
                  ready_q   <= 1'b1;
                  state     <= S_ONE;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state    <= S_EMPTY;
               tvalid_q <= 1'b0;
               ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.master_entry_ready = ready_q;
   assign bus.m_axis_tvalid      = tvalid_q;
   assign bus.m_axis_tdata       = main_data;
   assign bus.m_axis_tkeep       = main_keep;
   assign bus.m_axis_tlast       = main_last;
   assign pkt_count              = pkt_q;
   assign err_sparse             = err_q;
endmodule

// File: tb/tb_resizer_master_port.sv
// Directed bench for resizer_master_port; a second instance with a 2-bit
// packet counter runs in lockstep to exercise counter wrap.
module tb_resizer_master_port;
   logic clk;
   logic rst;
   logic [15:0] pkt_count;
   logic        err_sparse;
   logic [1:0]  pkt_count_w;
   logic        err_sparse_w;

   int n_chk = 0;
   int n_bad = 0;

   resizer_master_port_if #(.T_DATA_WIDTH(1), .M_KEEP_WIDTH(2)) ifm ();
   resizer_master_port_if #(.T_DATA_WIDTH(1), .M_KEEP_WIDTH(2)) ifw ();

   assign ifw.master_entry       = ifm.master_entry;
   assign ifw.master_entry_valid = ifm.master_entry_valid;
   assign ifw.m_axis_tready      = ifm.m_axis_tready;

   resizer_master_port #(.T_DATA_WIDTH(1), .M_KEEP_WIDTH(2), .PKT_CNT_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (ifm),
      .pkt_count  (pkt_count),
      .err_sparse (err_sparse)
   );

   resizer_master_port #(.T_DATA_WIDTH(1), .M_KEEP_WIDTH(2), .PKT_CNT_WIDTH(2)) dut_w (
      .clk        (clk),
      .rst        (rst),
      .bus        (ifw),
      .pkt_count  (pkt_count_w),
      .err_sparse (err_sparse_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // lane1 | lane0, each lane = {last, keep, data}
   localparam logic [5:0] E_A     = 6'b111_110; // tdata 10 keep 11 last
   localparam logic [5:0] E_A2    = 6'b010_011; // tdata 01 keep 11
   localparam logic [5:0] E_B2    = 6'b111_111; // tdata 11 keep 11 last
   localparam logic [5:0] E_C     = 6'b110_110; // tdata 00 keep 11 last
   localparam logic [5:0] E_NULL  = 6'b000_000;
   localparam logic [5:0] E_SPRS  = 6'b111_000; // tdata 10 keep 10 last
   localparam logic [5:0] E_ZLAST = 6'b000_100; // keep 00 last

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic [1:0] d, input logic [1:0] k, input logic l);
      chk({tag, "_tvalid"}, 32'(ifm.m_axis_tvalid), 32'd1);
      chk({tag, "_tdata"},  32'(ifm.m_axis_tdata),  32'(d));
      chk({tag, "_tkeep"},  32'(ifm.m_axis_tkeep),  32'(k));
      chk({tag, "_tlast"},  32'(ifm.m_axis_tlast),  32'(l));
   endtask

   initial begin
      rst = 1'b1;
      ifm.master_entry       = E_A;
      ifm.master_entry_valid = 1'b1;
      ifm.m_axis_tready      = 1'b1;

      // reset with valid asserted
      repeat (3) step();
      chk("rst_tvalid", 32'(ifm.m_axis_tvalid), 32'd0);
      chk("rst_tdata",  32'(ifm.m_axis_tdata),  32'd0);
      chk("rst_tkeep",  32'(ifm.m_axis_tkeep),  32'd0);
      chk("rst_tlast",  32'(ifm.m_axis_tlast),  32'd0);
      chk("rst_ready",  32'(ifm.master_entry_ready), 32'd0);
      chk("rst_pkt",    32'(pkt_count), 32'd0);
      chk("rst_err",    32'(err_sparse), 32'd0);

      rst = 1'b0;
      step();
      chk("post_rst_ready",  32'(ifm.master_entry_ready), 32'd1);
      chk("post_rst_tvalid", 32'(ifm.m_axis_tvalid), 32'd0);

      // pass-through of E_A
      step();
      chk_beat("pass", 2'b10, 2'b11, 1'b1);
      chk("pass_pkt0", 32'(pkt_count), 32'd0);
      ifm.master_entry_valid = 1'b0;
      step();
      chk("pass_pkt1",  32'(pkt_count), 32'd1);
      chk("wrap_1",     32'(pkt_count_w), 32'd1);
      chk("pass_empty", 32'(ifm.m_axis_tvalid), 32'd0);

      // backpressure: A2 then B2 with sink stalled
      ifm.m_axis_tready      = 1'b0;
      ifm.master_entry_valid = 1'b1;
      ifm.master_entry       = E_A2;
      step();
      chk_beat("bp_a", 2'b01, 2'b11, 1'b0);
      chk("bp_ready_a", 32'(ifm.master_entry_ready), 32'd1);
      ifm.master_entry = E_B2;
      step();
      chk("bp_ready_b", 32'(ifm.master_entry_ready), 32'd0);
      chk_beat("bp_hold1", 2'b01, 2'b11, 1'b0);
      ifm.master_entry = E_C;
      step();
      chk("bp_ready_c", 32'(ifm.master_entry_ready), 32'd0);
      chk_beat("bp_hold2", 2'b01, 2'b11, 1'b0);
      ifm.master_entry_valid = 1'b0;
      ifm.m_axis_tready      = 1'b1;
      step();
      chk_beat("bp_drain_b", 2'b11, 2'b11, 1'b1);
      chk("bp_ready_up", 32'(ifm.master_entry_ready), 32'd1);
      chk("bp_pkt1",     32'(pkt_count), 32'd1);
      step();
      chk("bp_pkt2",  32'(pkt_count), 32'd2);
      chk("wrap_2",   32'(pkt_count_w), 32'd2);
      chk("bp_empty", 32'(ifm.m_axis_tvalid), 32'd0);

      // null drop between A2 and B2
      ifm.master_entry_valid = 1'b1;
      ifm.master_entry       = E_A2;
      step();
      chk_beat("null_a", 2'b01, 2'b11, 1'b0);
      ifm.master_entry = E_NULL;
      step();
      chk("null_gap", 32'(ifm.m_axis_tvalid), 32'd0);
      ifm.master_entry = E_B2;
      step();
      chk_beat("null_b", 2'b11, 2'b11, 1'b1);
      ifm.master_entry_valid = 1'b0;
      step();
      chk("null_pkt3", 32'(pkt_count), 32'd3);
      chk("wrap_3",    32'(pkt_count_w), 32'd3);
      chk("null_end",  32'(ifm.m_axis_tvalid), 32'd0);

      // sparse keep followed back-to-back by a zero-keep last beat
      ifm.master_entry_valid = 1'b1;
      ifm.master_entry       = E_SPRS;
      step();
      chk_beat("sparse", 2'b10, 2'b10, 1'b1);
      chk("sparse_err_pre", 32'(err_sparse), 32'd0);
      ifm.master_entry = E_ZLAST;
      step();
      chk("sparse_err", 32'(err_sparse), 32'd1);
      chk_beat("zlast", 2'b00, 2'b00, 1'b1);
      chk("sparse_pkt4", 32'(pkt_count), 32'd4);
      chk("wrap_0",      32'(pkt_count_w), 32'd0);
      ifm.master_entry_valid = 1'b0;
      step();
      chk("zlast_pkt5",  32'(pkt_count), 32'd5);
      chk("wrap_1b",     32'(pkt_count_w), 32'd1);
      chk("err_sticky",  32'(err_sparse), 32'd1);
      chk("zlast_empty", 32'(ifm.m_axis_tvalid), 32'd0);

      // sustained stream: A2, B2 on consecutive cycles
      ifm.master_entry_valid = 1'b1;
      ifm.master_entry       = E_A2;
      step();
      chk_beat("strm_a", 2'b01, 2'b11, 1'b0);
      ifm.master_entry = E_B2;
      step();
      chk_beat("strm_b", 2'b11, 2'b11, 1'b1);
      ifm.master_entry_valid = 1'b0;
      step();
      chk("strm_pkt6",    32'(pkt_count), 32'd6);
      chk("err_sticky2",  32'(err_sparse), 32'd1);

      // reset while a beat is held under backpressure
      ifm.m_axis_tready      = 1'b0;
      ifm.master_entry_valid = 1'b1;
      ifm.master_entry       = E_A2;
      step();
      chk("mid_loaded", 32'(ifm.m_axis_tvalid), 32'd1);
      rst = 1'b1;
      step();
      chk("mid_tvalid", 32'(ifm.m_axis_tvalid), 32'd0);
      chk("mid_tkeep",  32'(ifm.m_axis_tkeep),  32'd0);
      chk("mid_pkt",    32'(pkt_count), 32'd0);
      chk("mid_err",    32'(err_sparse), 32'd0);
      chk("mid_ready",  32'(ifm.master_entry_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
